// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
//
// Elastic FIFO between instruction memory and the decode stage. Each entry holds
// a fetched instruction word and its PC. The head entry is presented to decode
// along with two operand candidates for the decode operand multiplexer: the low
// 16 bits of the instruction (immediate) and the head PC plus 4. A flush drops
// every held entry when a branch or jump is taken.
//
// Parameters
//   DEPTH    number of entries (power of two, >= 2)
//   INSTR_W  instruction width
//   PC_W     program-counter width, also the width of out_pc_plus4
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   in_valid      fetch presents in_instr/in_pc
//   in_ready      buffer can accept an entry this cycle
//   in_instr      fetched instruction word
//   in_pc         address of in_instr
//   flush         discard all entries
//   out_valid     head entry valid
//   out_ready     decode consumes the head this cycle
//   out_instr     head instruction
//   out_pc        head PC
//   out_imm16     head instruction bits [15:0]
//   out_pc_plus4  head PC + 4, wrapping modulo 2^PC_W
//   level         current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic [15:0]              out_imm16,
    output logic [PC_W-1:0]          out_pc_plus4,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Storage is data-only and needs no reset: nothing is read from it unless
    // count says the slot holds a live entry.
    logic [INSTR_W-1:0] instrMem [DEPTH];
    logic [PC_W-1:0]    pcMem    [DEPTH];

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;

    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign level     = count;

    // A flush cycle suppresses both handshakes so the flushed word is never
    // written and no pointer moves except the rd_ptr snap below.
    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
            rdPtr <= wrPtr;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            instrMem[wrPtr] <= in_instr;
            pcMem[wrPtr]    <= in_pc;
        end
    end

    // Head outputs come straight from registered state; they read as zero
    // whenever the buffer is empty so decode never sees stale entries.
    logic [INSTR_W-1:0] headInstr;
    logic [PC_W-1:0]    headPc;

    always_comb begin
        headInstr = '0;
        headPc    = '0;
        if (out_valid) begin
            headInstr = instrMem[rdPtr];
            headPc    = pcMem[rdPtr];
        end
    end

    assign out_instr    = headInstr;
    assign out_pc       = headPc;
    assign out_imm16    = headInstr[15:0];
    assign out_pc_plus4 = out_valid ? (headPc + PC_W'(4)) : '0;

endmodule
